// File: rtl/div_unit_pkg.sv
// Shared encodings for the radix-2 restoring divider.
// State codes and handshake levels used by div_unit.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider, {remainder, quotient} on result_o.
// Define DIV_SIGNED_EN to honour signed_i (abs on entry, sign fix on exit).
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   div_state_e         state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [WIDTH-1:0]   dvd, dvd_n;
   logic [WIDTH-1:0]   dvs, dvs_n;
   logic [WIDTH-1:0]   rem, rem_n;
   logic               neg_q, neg_q_n;
   logic               neg_r, neg_r_n;
   logic [2*WIDTH-1:0] result_n;
   logic               ready_n, busy_n;

   logic [WIDTH:0]     rem_sh, diff;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH-1:0]   q_fix, r_fix;
   logic               sgn_q, sgn_r;

`ifdef DIV_SIGNED_EN
   always_comb begin
      sgn_r = signed_i & opdata1_i[WIDTH-1];
      sgn_q = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      a_abs = sgn_r ? -opdata1_i : opdata1_i;
      b_abs = (signed_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
      q_fix = neg_q ? -dvd : dvd;
      r_fix = neg_r ? -rem : rem;
   end
`else
   logic unused_signed;
   assign unused_signed = ^{signed_i, neg_q, neg_r};

   always_comb begin
      sgn_r = 1'b0;
      sgn_q = 1'b0;
      a_abs = opdata1_i;
      b_abs = opdata2_i;
      q_fix = dvd;
      r_fix = rem;
   end
`endif

   // The dividend register doubles as the quotient shift register.
   assign rem_sh = {rem, dvd[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dvs};

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      dvd_n    = dvd;
      dvs_n    = dvs;
      rem_n    = rem;
      neg_q_n  = neg_q;
      neg_r_n  = neg_r;
      result_n = '0;
      ready_n  = DIV_RESULT_NOT_READY;
      busy_n   = 1'b0;
      unique case (state)
         DIV_FREE: begin
            if (start_i == DIV_START && !annul_i) begin
               dvd_n   = a_abs;
               dvs_n   = b_abs;
               rem_n   = '0;
               neg_q_n = sgn_q;
               neg_r_n = sgn_r;
               cnt_n   = '0;
               busy_n  = 1'b1;
               if (opdata2_i == '0) begin
                  state_n = DIV_BYZERO;
                  dvd_n   = '0;
               end else begin
                  state_n = DIV_ON;
               end
            end
         end
         DIV_BYZERO: begin
            state_n = DIV_END;
            busy_n  = 1'b1;
         end
         DIV_ON: begin
            if (annul_i) begin
               state_n = DIV_FREE;
            end else begin
               busy_n = 1'b1;
               cnt_n  = cnt + CNT_W'(1);
               dvd_n  = {dvd[WIDTH-2:0], ~diff[WIDTH]};
               rem_n  = diff[WIDTH] ? rem_sh[WIDTH-1:0]
                                    : diff[WIDTH-1:0];
               if (cnt == CNT_W'(WIDTH - 1))
                  state_n = DIV_END;
            end
         end
         DIV_END: begin
            if (start_i == DIV_STOP) begin
               state_n = DIV_FREE;
            end else begin
               busy_n   = 1'b1;
               ready_n  = DIV_RESULT_READY;
               result_n = {r_fix, q_fix};
            end
         end
         default: state_n = DIV_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= DIV_FREE;
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= DIV_RESULT_NOT_READY;
         busy_o   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         dvd      <= dvd_n;
         dvs      <= dvs_n;
         rem      <= rem_n;
         neg_q    <= neg_q_n;
         neg_r    <= neg_r_n;
         result_o <= result_n;
         ready_o  <= ready_n;
         busy_o   <= busy_n;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit at WIDTH=32.
// Follows DIV_SIGNED_EN so expectations match the build.
module tb_div_unit;

   localparam int W = 32;
`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           signed_i;
   logic [W-1:0]   opdata1_i;
   logic [W-1:0]   opdata2_i;
   logic           start_i;
   logic           annul_i;
   logic [2*W-1:0] result_o;
   logic           ready_o;
   logic           busy_o;

   int errors = 0;
   int checks = 0;
   logic [2*W-1:0] exp_q[$];

   div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .signed_i  (signed_i),
      .opdata1_i (opdata1_i),
      .opdata2_i (opdata2_i),
      .start_i   (start_i),
      .annul_i   (annul_i),
      .result_o  (result_o),
      .ready_o   (ready_o),
      .busy_o    (busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [2*W-1:0] model(input logic s,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic signed [W-1:0] sa, sb, q, r;
      if (b == '0) return '0;
      if (s & SIGNED_EN) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'h0, 32'h8000_0000};
         sa = a;
         sb = b;
         q  = sa / sb;
         r  = sa % sb;
         return {r, q};
      end
      return {a % b, a / b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds start until ready; lat counts edges after the sampling edge.
   task automatic do_div(input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         output int lat, output logic [2*W-1:0] res);
      exp_q.push_back(model(s, a, b));
      signed_i  = s;
      opdata1_i = a;
      opdata2_i = b;
      start_i   = 1'b1;
      lat = -1;
      res = '0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (n == 0) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_i  = ~s;
         end
         if (ready_o) begin
            lat = n;
            res = result_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      signed_i = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      start_i = 1'b0;
      annul_i = 1'b0;
      tick();
      tick();
      checks++;
      if (result_o !== '0) begin
         errors++;
         $display("FAIL reset_result: got %h want 0", result_o);
      end
      checks++;
      if (ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b want 0", ready_o);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b want 0", busy_o);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_unsigned();
      int lat;
      logic [2*W-1:0] res, exp;
      do_div(1'b0, 32'd100, 32'd7, lat, res);
      exp = exp_q.pop_front();
      checks++;
      if (lat !== W + 1) begin
         errors++;
         $display("FAIL unsigned_latency: got %0d want %0d", lat, W + 1);
      end
      checks++;
      if (res !== exp || res !== {32'h2, 32'hE}) begin
         errors++;
         $display("FAIL unsigned_100_7: got %h want %h", res, exp);
      end
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL unsigned_busy_end: got %b want 1", busy_o);
      end
      tick();
      checks++;
      if (ready_o !== 1'b1 || result_o !== exp) begin
         errors++;
         $display("FAIL unsigned_hold: ready %b res %h want 1 %h",
                  ready_o, result_o, exp);
      end
      start_i = 1'b0;
      tick();
      checks++;
      if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0) begin
         errors++;
         $display("FAIL unsigned_release: ready %b busy %b res %h want 0 0 0",
                  ready_o, busy_o, result_o);
      end
   endtask

   task automatic test_signed();
      int lat;
      logic [2*W-1:0] res, exp, want;
      want = SIGNED_EN ? {32'hFFFF_FFFF, 32'hFFFF_FFFD}
                       : {32'h0000_0001, 32'h7FFF_FFFC};
      do_div(1'b1, 32'hFFFF_FFF9, 32'h2, lat, res);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp || res !== want) begin
         errors++;
         $display("FAIL signed_m7_2: got %h want %h", res, want);
      end
      start_i = 1'b0;
      tick();
      want = SIGNED_EN ? {32'h0, 32'h8000_0000}
                       : {32'h8000_0000, 32'h0};
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp || res !== want) begin
         errors++;
         $display("FAIL signed_overflow: got %h want %h", res, want);
      end
      checks++;
      if (lat !== W + 1) begin
         errors++;
         $display("FAIL signed_latency: got %0d want %0d", lat, W + 1);
      end
      start_i = 1'b0;
      tick();
   endtask

   task automatic test_byzero();
      logic [2*W-1:0] exp;
      exp_q.push_back(model(1'b0, 32'd5, 32'd0));
      signed_i = 1'b0;
      opdata1_i = 32'd5;
      opdata2_i = 32'd0;
      start_i = 1'b1;
      tick();
      checks++;
      if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
         errors++;
         $display("FAIL byzero_edge1: busy %b ready %b want 1 0",
                  busy_o, ready_o);
      end
      tick();
      checks++;
      if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
         errors++;
         $display("FAIL byzero_edge2: busy %b ready %b want 1 0",
                  busy_o, ready_o);
      end
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (ready_o !== 1'b1 || busy_o !== 1'b1 || result_o !== exp) begin
         errors++;
         $display("FAIL byzero_ready: ready %b busy %b res %h want 1 1 %h",
                  ready_o, busy_o, result_o, exp);
      end
      start_i = 1'b0;
      tick();
      checks++;
      if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
         errors++;
         $display("FAIL byzero_release: busy %b ready %b want 0 0",
                  busy_o, ready_o);
      end
   endtask

   task automatic test_annul();
      int lat, seen;
      logic [2*W-1:0] res, exp;
      signed_i = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) tick();
      annul_i = 1'b1;
      start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
         errors++;
         $display("FAIL annul_flush: busy %b ready %b res %h want 0 0 0",
                  busy_o, ready_o, result_o);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready_o || busy_o) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL annul_quiet: active cycles %0d want 0", seen);
      end
      do_div(1'b0, 32'd100, 32'd7, lat, res);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp || lat !== W + 1) begin
         errors++;
         $display("FAIL annul_restart: res %h lat %0d want %h %0d",
                  res, lat, exp, W + 1);
      end
      start_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [2*W-1:0] res, exp;
      signed_i = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      start_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
         errors++;
         $display("FAIL reset_mid: busy %b ready %b res %h want 0 0 0",
                  busy_o, ready_o, result_o);
      end
      tick();
      do_div(1'b0, 32'd1000, 32'd3, lat, res);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp || lat !== W + 1) begin
         errors++;
         $display("FAIL reset_mid_restart: res %h lat %0d want %h %0d",
                  res, lat, exp, W + 1);
      end
      start_i = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      logic s;
      logic [W-1:0] a, b;
      logic [2*W-1:0] res, exp;
      for (int i = 0; i < 6; i++) begin
         s = 1'($urandom);
         a = $urandom;
         b = (i == 2) ? 32'd1 : ($urandom >> $urandom_range(0, 28));
         if (b == '0) b = 32'd3;
         do_div(s, a, b, lat, res);
         exp = exp_q.pop_front();
         checks++;
         if (res !== exp || lat !== W + 1) begin
            errors++;
            $display("FAIL b2b_%0d: %h/%h s=%b res %h lat %0d want %h %0d",
                     i, a, b, s, res, lat, exp, W + 1);
         end
         start_i = 1'b0;
         tick();
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_byzero();
      test_annul();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
